// File: rtl/acia6850_pkg.sv
// Shared constants and state types for the host-side 6850 ACIA.
// Covers register selects, status bit positions, divide codes and FSM states.
package acia6850_pkg;

  localparam logic RS_CTRL = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int ST_RDRF = 0;
  localparam int ST_TDRE = 1;
  localparam int ST_DCD  = 2;
  localparam int ST_CTS  = 3;
  localparam int ST_FE   = 4;
  localparam int ST_OVRN = 5;
  localparam int ST_PE   = 6;
  localparam int ST_IRQ  = 7;

  localparam logic [1:0] DIV1   = 2'b00;
  localparam logic [1:0] DIV16  = 2'b01;
  localparam logic [1:0] DIV64  = 2'b10;
  localparam logic [1:0] MRESET = 2'b11;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

  // Last tick index within one bit (N-1) for a divide code.
  function automatic logic [5:0] divLast(input logic [1:0] code);
    case (code)
      DIV16:   return 6'd15;
      DIV64:   return 6'd63;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/acia6850_host_if.sv
// Host CPU bus side of the ACIA: access strobe, register select, data and interrupt.
interface acia6850_host_if;
  logic       bus_en;
  logic       rs;
  logic       rw;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq_n;

  modport master (output bus_en, rs, rw, din, input dout, irq_n);
  modport slave  (input bus_en, rs, rw, din, output dout, irq_n);
endinterface

// File: rtl/acia6850_bitclk.sv
// Prescaler plus divide-by-N bit counter; restart realigns both to a line edge.
// Emits a pulse at the end of each bit and one at the half-bit point.
module acia6850_bitclk import acia6850_pkg::*; #(
  parameter int CLKDIV = 4
) (
  input  logic       clk_i,
  input  logic       rstN_i,
  input  logic       hold_i,
  input  logic       restart_i,
  input  logic [1:0] divCode_i,
  output logic       bitEnd_o,
  output logic       midBit_o
);
  localparam int PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [PW-1:0] pre_q;
  logic [5:0]    cnt_q;
  logic [5:0]    last;
  logic [5:0]    half;
  logic          tick;

  assign tick     = (pre_q == PW'(CLKDIV - 1));
  assign last     = divLast(divCode_i);
  // In /1 mode half collapses to 0, so the start bit is sampled on the first tick.
  assign half     = last >> 1;
  assign bitEnd_o = tick && (cnt_q == last) && !hold_i;
  assign midBit_o = tick && (cnt_q == half) && !hold_i;

  always_ff @(posedge clk_i) begin
    if (!rstN_i || hold_i || restart_i) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
      cnt_q <= (cnt_q == last) ? 6'd0 : cnt_q + 6'd1;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

endmodule

// File: rtl/acia6850_host.sv
// Host-side 6850-compatible ACIA talking 8N1 to the IKBD MCU SCI.
// Two bus registers (control/status, data), independent RX and TX bit engines.
module acia6850_host import acia6850_pkg::*; #(
  parameter int CLKDIV = 4
) (
  input  logic             mcu_clx2,
  input  logic             mcu_rst,
  acia6850_host_if.slave   bus,
  input  logic             rxd,
  output logic             txd,
  output logic             rts_n
);
  logic [7:0] cr_q, rdr_q, tdr_q, rxShift_q, txShift_q, status;
  logic       rdrf_q, tdre_q, fe_q, ovrn_q, ovrnArm_q, irqN_q, txLine_q;
  logic [1:0] rxSync_q;
  logic       rxPrev_q, rxIn;
  logic [2:0] rxBit_q, txBit_q;
  rxState_t   rxState_q;
  txState_t   txState_q;
  logic       ctrlWr, dataWr, statRd, dataRd, mresetWr, mreset;
  logic       rxEnd, rxMid, txEnd, rxRestart, irq_d;
  logic       unusedCrBits;

  assign ctrlWr   = bus.bus_en && !bus.rw && (bus.rs == RS_CTRL);
  assign dataWr   = bus.bus_en && !bus.rw && (bus.rs == RS_DATA);
  assign statRd   = bus.bus_en &&  bus.rw && (bus.rs == RS_CTRL);
  assign dataRd   = bus.bus_en &&  bus.rw && (bus.rs == RS_DATA);
  assign mresetWr = ctrlWr && (bus.din[1:0] == MRESET);
  assign mreset   = (cr_q[1:0] == MRESET);
  assign rxIn     = rxSync_q[1];
  assign unusedCrBits = ^cr_q[4:2];

  assign rxRestart = ((rxState_q == RX_IDLE) && rxPrev_q && !rxIn) ||
                     ((rxState_q == RX_START) && rxMid && !rxIn);

  acia6850_bitclk #(.CLKDIV(CLKDIV)) rxClk (
    .clk_i(mcu_clx2), .rstN_i(mcu_rst), .hold_i(mreset), .restart_i(rxRestart),
    .divCode_i(cr_q[1:0]), .bitEnd_o(rxEnd), .midBit_o(rxMid)
  );

  acia6850_bitclk #(.CLKDIV(CLKDIV)) txClk (
    .clk_i(mcu_clx2), .rstN_i(mcu_rst), .hold_i(mreset), .restart_i(1'b0),
    .divCode_i(cr_q[1:0]), .bitEnd_o(txEnd), .midBit_o()
  );

  assign irq_d = (cr_q[7] & (rdrf_q | ovrn_q)) | ((cr_q[6:5] == 2'b01) & tdre_q);

  always_comb begin
    status          = '0;
    status[ST_IRQ]  = irq_d;
    status[ST_PE]   = 1'b0;
    status[ST_OVRN] = ovrn_q;
    status[ST_FE]   = fe_q;
    status[ST_CTS]  = 1'b0;
    status[ST_DCD]  = 1'b0;
    status[ST_TDRE] = tdre_q;
    status[ST_RDRF] = rdrf_q;
  end

  assign bus.dout  = (bus.rs == RS_DATA) ? rdr_q : status;
  assign bus.irq_n = irqN_q;
  assign rts_n     = (cr_q[6:5] == 2'b10);
  assign txd       = (cr_q[6:5] == 2'b11) ? 1'b0 : txLine_q;

  always_ff @(posedge mcu_clx2) begin
    if (!mcu_rst) begin
      cr_q <= 8'h03;
    end else if (ctrlWr) begin
      cr_q <= bus.din;
    end
  end

  always_ff @(posedge mcu_clx2) begin
    if (!mcu_rst) begin
      rxSync_q <= 2'b11;
      rxPrev_q <= 1'b1;
    end else begin
      rxSync_q <= {rxSync_q[0], rxd};
      rxPrev_q <= rxSync_q[1];
    end
  end

  // Frame completion is evaluated after the read side effects so it wins a same-clock collision.
  always_ff @(posedge mcu_clx2) begin
    if (!mcu_rst || mresetWr) begin
      rxState_q <= RX_IDLE;
      rxShift_q <= '0;
      rxBit_q   <= '0;
      rdr_q     <= '0;
      rdrf_q    <= 1'b0;
      fe_q      <= 1'b0;
      ovrn_q    <= 1'b0;
      ovrnArm_q <= 1'b0;
    end else begin
      if (statRd) ovrnArm_q <= 1'b1;
      if (dataRd) begin
        rdrf_q    <= 1'b0;
        fe_q      <= 1'b0;
        ovrnArm_q <= 1'b0;
        if (ovrnArm_q) ovrn_q <= 1'b0;
      end
      if (mreset) begin
        rxState_q <= RX_IDLE;
      end else begin
        case (rxState_q)
          RX_IDLE: if (rxPrev_q && !rxIn) begin
            rxState_q <= RX_START;
            rxBit_q   <= '0;
          end
          RX_START: if (rxMid) rxState_q <= rxIn ? RX_IDLE : RX_DATA;
          RX_DATA: if (rxEnd) begin
            rxShift_q <= {rxIn, rxShift_q[7:1]};
            rxBit_q   <= rxBit_q + 3'd1;
            if (rxBit_q == 3'd7) rxState_q <= RX_STOP;
          end
          RX_STOP: if (rxEnd) begin
            rxState_q <= RX_IDLE;
            if (!rxIn) begin
              rdr_q  <= rxShift_q;
              rdrf_q <= 1'b1;
              fe_q   <= 1'b1;
            end else if (rdrf_q) begin
              ovrn_q <= 1'b1;
            end else begin
              rdr_q  <= rxShift_q;
              rdrf_q <= 1'b1;
              fe_q   <= 1'b0;
            end
          end
          default: rxState_q <= RX_IDLE;
        endcase
      end
    end
  end

  // STOP shares the load path with IDLE so a pending byte follows with no idle gap.
  always_ff @(posedge mcu_clx2) begin
    if (!mcu_rst || mresetWr) begin
      txState_q <= TX_IDLE;
      txShift_q <= '0;
      txBit_q   <= '0;
      txLine_q  <= 1'b1;
      tdr_q     <= '0;
      tdre_q    <= 1'b1;
    end else begin
      if (mreset) begin
        txState_q <= TX_IDLE;
        txLine_q  <= 1'b1;
      end else begin
        case (txState_q)
          TX_IDLE, TX_STOP: if (txEnd) begin
            if (!tdre_q) begin
              txShift_q <= tdr_q;
              tdre_q    <= 1'b1;
              txLine_q  <= 1'b0;
              txState_q <= TX_START;
            end else begin
              txLine_q  <= 1'b1;
              txState_q <= TX_IDLE;
            end
          end
          TX_START: if (txEnd) begin
            txLine_q  <= txShift_q[0];
            txShift_q <= {1'b0, txShift_q[7:1]};
            txBit_q   <= '0;
            txState_q <= TX_DATA;
          end
          TX_DATA: if (txEnd) begin
            if (txBit_q == 3'd7) begin
              txLine_q  <= 1'b1;
              txState_q <= TX_STOP;
            end else begin
              txLine_q  <= txShift_q[0];
              txShift_q <= {1'b0, txShift_q[7:1]};
              txBit_q   <= txBit_q + 3'd1;
            end
          end
          default: txState_q <= TX_IDLE;
        endcase
      end
      if (dataWr) begin
        tdr_q  <= bus.din;
        tdre_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge mcu_clx2) begin
    if (!mcu_rst || mresetWr) begin
      irqN_q <= 1'b1;
    end else begin
      irqN_q <= ~irq_d;
    end
  end

endmodule

// File: tb/tb_acia6850_host.sv
// Directed bench for the host ACIA: register vector table plus serial RX/TX sequences.
module tb_acia6850_host;

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] din;
    logic [7:0] expDout;
    logic       expIrqN;
    logic       expRtsN;
  } vec_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  logic rxd  = 1'b1;
  logic txd;
  logic rtsN;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[10];

  acia6850_host_if busIf();

  acia6850_host #(.CLKDIV(4)) dut (
    .mcu_clx2(clk),
    .mcu_rst (rstN),
    .bus     (busIf),
    .rxd     (rxd),
    .txd     (txd),
    .rts_n   (rtsN)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h", name, actual, expected);
    end
  endtask

  task automatic busWrite(input logic rs, input logic [7:0] data);
    @(negedge clk);
    busIf.bus_en = 1'b1;
    busIf.rw     = 1'b0;
    busIf.rs     = rs;
    busIf.din    = data;
    @(negedge clk);
    busIf.bus_en = 1'b0;
    busIf.rw     = 1'b1;
  endtask

  task automatic busRead(input logic rs, output logic [7:0] data);
    @(negedge clk);
    busIf.bus_en = 1'b1;
    busIf.rw     = 1'b1;
    busIf.rs     = rs;
    #1 data = busIf.dout;
    @(negedge clk);
    busIf.bus_en = 1'b0;
  endtask

  task automatic readCheck(input logic rs, input logic [7:0] expected, input string name);
    logic [7:0] d;
    busRead(rs, d);
    checkOutput(name, d, expected);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [7:0] d;
    if (v.rw) begin
      busRead(v.rs, d);
      checkOutput($sformatf("vec%0d dout", idx), d, v.expDout);
    end else begin
      busWrite(v.rs, v.din);
    end
    waitClocks(1);
    checkOutput($sformatf("vec%0d irq_n", idx), {7'b0, busIf.irq_n}, {7'b0, v.expIrqN});
    checkOutput($sformatf("vec%0d rts_n", idx), {7'b0, rtsN}, {7'b0, v.expRtsN});
  endtask

  // Drives one 8N1 frame at 256 clocks per bit; optionally issues a master reset at a given bit.
  task automatic sendFrame(input logic [7:0] data, input logic stopBit, input int mrAtBit);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      if (i == mrAtBit) begin
        busWrite(1'b0, 8'h03);
        waitClocks(254);
      end else begin
        waitClocks(256);
      end
    end
    rxd = 1'b1;
  endtask

  // Entered about 100 clocks into the start bit; samples each bit once near its middle.
  task automatic checkTxFrame(input logic [7:0] data, input logic doWrite, input logic [7:0] nextData,
                              input string tag);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("%s txd bit%0d", tag, i), {7'b0, txd}, {7'b0, frame[i]});
      if (doWrite && i == 3) begin
        busWrite(1'b1, nextData);
        readCheck(1'b0, 8'h00, {tag, " status tdre busy"});
        waitClocks(252);
      end else begin
        waitClocks(256);
      end
    end
  endtask

  initial begin
    bit found;

    busIf.bus_en = 1'b0;
    busIf.rw     = 1'b1;
    busIf.rs     = 1'b0;
    busIf.din    = 8'h00;

    vecs[0] = '{1'b0, 1'b1, 8'h00, 8'h02, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'h96, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h02, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'hA2, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h82, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'hC2, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h02, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 8'h96, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 8'h02, 1'b1, 1'b0};

    waitClocks(4);
    rstN = 1'b1;
    waitClocks(1);
    checkOutput("reset txd", {7'b0, txd}, 8'h01);
    checkOutput("reset irq_n", {7'b0, busIf.irq_n}, 8'h01);

    for (int i = 0; i < 10; i++) applyStimulus(i, vecs[i]);

    $display("[TB] receive single frame");
    sendFrame(8'hA5, 1'b1, -1);
    checkOutput("rx A5 irq_n", {7'b0, busIf.irq_n}, 8'h00);
    readCheck(1'b0, 8'h83, "rx A5 status");
    readCheck(1'b1, 8'hA5, "rx A5 rdr");
    readCheck(1'b0, 8'h02, "rx A5 status after read");
    checkOutput("rx A5 irq_n after read", {7'b0, busIf.irq_n}, 8'h01);

    $display("[TB] overrun with armed clear");
    sendFrame(8'h11, 1'b1, -1);
    sendFrame(8'h22, 1'b1, -1);
    readCheck(1'b0, 8'hA3, "ovrn status");
    readCheck(1'b1, 8'h11, "ovrn rdr");
    readCheck(1'b0, 8'h02, "ovrn cleared status");

    $display("[TB] overrun without arming");
    readCheck(1'b1, 8'h11, "disarm rdr");
    sendFrame(8'h33, 1'b1, -1);
    sendFrame(8'h44, 1'b1, -1);
    readCheck(1'b1, 8'h33, "unarmed rdr");
    readCheck(1'b0, 8'hA2, "ovrn kept status");
    readCheck(1'b1, 8'h33, "armed rdr");
    readCheck(1'b0, 8'h02, "ovrn cleared late status");

    $display("[TB] framing error and false start");
    sendFrame(8'h3C, 1'b0, -1);
    readCheck(1'b0, 8'h93, "fe status");
    readCheck(1'b1, 8'h3C, "fe rdr");
    readCheck(1'b0, 8'h02, "fe cleared status");
    rxd = 1'b0;
    waitClocks(50);
    rxd = 1'b1;
    waitClocks(700);
    readCheck(1'b0, 8'h02, "glitch status");

    $display("[TB] transmit back-to-back frames");
    busWrite(1'b0, 8'hB6);
    busWrite(1'b1, 8'h80);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (txd == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("tx start found", {7'b0, found}, 8'h01);
    readCheck(1'b0, 8'h82, "tx tdre reloaded status");
    waitClocks(98);
    checkTxFrame(8'h80, 1'b1, 8'h55, "tx1");
    checkTxFrame(8'h55, 1'b0, 8'h00, "tx2");
    checkOutput("tx idle txd", {7'b0, txd}, 8'h01);
    readCheck(1'b0, 8'h82, "tx idle status");
    checkOutput("tx idle irq_n", {7'b0, busIf.irq_n}, 8'h00);

    $display("[TB] break");
    busWrite(1'b0, 8'hF6);
    waitClocks(2);
    checkOutput("break rts_n", {7'b0, rtsN}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("break txd %0d", i), {7'b0, txd}, 8'h00);
      waitClocks(200);
    end
    busWrite(1'b1, 8'hFF);
    waitClocks(600);
    readCheck(1'b0, 8'h02, "break tx running status");
    checkOutput("break txd held", {7'b0, txd}, 8'h00);
    busWrite(1'b0, 8'h96);
    waitClocks(3000);
    checkOutput("break released txd", {7'b0, txd}, 8'h01);

    $display("[TB] master reset mid frame");
    sendFrame(8'h5A, 1'b1, 3);
    readCheck(1'b0, 8'h02, "mreset status");
    readCheck(1'b1, 8'h00, "mreset rdr");
    checkOutput("mreset irq_n", {7'b0, busIf.irq_n}, 8'h01);
    checkOutput("mreset txd", {7'b0, txd}, 8'h01);
    checkOutput("mreset rts_n", {7'b0, rtsN}, 8'h00);
    busWrite(1'b0, 8'h96);
    waitClocks(600);
    readCheck(1'b0, 8'h02, "post mreset status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
